pc_fetch: RTL

- Instruction-fetch and program-counter unit at the supply end of the instruction decoder.
- Each cycle it drives the fetch address to program ROM and passes the fetched 16-bit word to the decoder as rozkaz.
- It consumes the decoder's control outputs: jump, call/interrupt push, return pop and RST.
- It owns the return-address LIFO and reports that LIFO's empty/full state back to the decoder.

---
 rtl/pc_fetch_pkg.sv | 18 +
 rtl/stos_pc_lifo.sv | 58 +++++
 rtl/pc_fetch.sv | 107 ++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch / program-counter unit and its decoder.
package pc_fetch_pkg;
   localparam int PC_WIDTH_DEF = 8;
   localparam int I_WIDTH_DEF  = 16;

   // Must match the decoder's hard-coded exception vector.
   localparam logic [PC_WIDTH_DEF-1:0] WEKTOR_WYJATKU = 8'hFC;

   typedef logic [PC_WIDTH_DEF-1:0] adres_pc_t;

   typedef enum logic [2:0] {
      PC_INC,
      PC_SKOK,
      PC_STOS,
      PC_WYJATEK,
      PC_ZERO
   } pc_zrodlo_t;
endpackage

// File: rtl/stos_pc_lifo.sv
// Return-address LIFO built from a register array; only the count is reset.
module stos_pc_lifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full,
   output logic         overflow,
   output logic         underflow
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   logic [CW-1:0] count_q, count_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic          do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // Clear beats pop, pop beats push.
   assign do_pop    = ce & ~clear & pop & ~empty;
   assign do_push   = ce & ~clear & ~pop & push & ~full;
   assign underflow = ce & ~clear & pop & empty;
   assign overflow  = ce & ~clear & ~pop & push & full;

   assign top = mem_q[AW'(count_q - CW'(1))];

   always_comb begin
      count_d = count_q;
      if (ce && clear)
         count_d = '0;
      else if (do_pop)
         count_d = count_q - CW'(1);
      else if (do_push)
         count_d = count_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[AW'(count_q)] <= din;
   end
endmodule

// File: rtl/pc_fetch.sv
// Program counter, ROM fetch and return-address stack control feeding the decoder.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter int                   PC_WIDTH       = PC_WIDTH_DEF,
   parameter int                   I_WIDTH        = I_WIDTH_DEF,
   parameter int                   STOS_GLEBOKOSC = 8,
   parameter logic [PC_WIDTH-1:0]  WEKTOR_WYJATKU = PC_WIDTH'(pc_fetch_pkg::WEKTOR_WYJATKU)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pc_ce,
   output logic [PC_WIDTH-1:0] rom_adres,
   input  logic [I_WIDTH-1:0]  rom_dane,
   output logic [I_WIDTH-1:0]  rozkaz,
   input  logic                ID_rst,
   input  logic                skok_ID,
   input  logic [PC_WIDTH-1:0] adres_skok_ID,
   input  logic                skok_pc_ID,
   input  logic                ID_push_pc,
   input  logic                ID_pop_pc,
   input  logic                jest_przerwanie,
   output logic                ID_stos_pc_empty,
   output logic                ID_stos_pc_full,
   output logic [PC_WIDTH-1:0] pc,
   output logic                stos_pc_blad
);
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                blad_q, blad_d;
   pc_zrodlo_t          zrodlo;
   logic                lifo_push, lifo_pop, lifo_clear;
   logic                lifo_empty, lifo_full, lifo_ovf, lifo_udf;
   logic [PC_WIDTH-1:0] lifo_top, push_val;
   logic                powrot, wywolanie;

   assign rom_adres        = pc_q;
   assign pc               = pc_q;
   assign rozkaz           = rom_dane;
   assign ID_stos_pc_empty = lifo_empty;
   assign ID_stos_pc_full  = lifo_full;
   assign stos_pc_blad     = blad_q;

   assign powrot    = ID_pop_pc & skok_ID & skok_pc_ID;
   assign wywolanie = ID_push_pc & skok_ID & ~skok_pc_ID;

   // An interrupted instruction was suppressed, so it must be re-executed on RETI.
   assign push_val = jest_przerwanie ? pc_q : pc_q + 1'b1;

   always_comb begin
      zrodlo     = PC_INC;
      lifo_clear = 1'b0;
      lifo_pop   = 1'b0;
      lifo_push  = 1'b0;
      if (ID_rst) begin
         zrodlo     = PC_ZERO;
         lifo_clear = 1'b1;
      end else if (powrot) begin
         lifo_pop = 1'b1;
         zrodlo   = lifo_empty ? PC_WYJATEK : PC_STOS;
      end else if (wywolanie) begin
         lifo_push = 1'b1;
         zrodlo    = lifo_full ? PC_WYJATEK : PC_SKOK;
      end else if (skok_ID) begin
         zrodlo = PC_SKOK;
      end
   end

   always_comb begin
      unique case (zrodlo)
         PC_SKOK:    pc_d = adres_skok_ID;
         PC_STOS:    pc_d = lifo_top;
         PC_WYJATEK: pc_d = WEKTOR_WYJATKU;
         PC_ZERO:    pc_d = '0;
         default:    pc_d = pc_q + 1'b1;
      endcase
   end

   assign blad_d = ID_rst ? 1'b0 : (blad_q | lifo_ovf | lifo_udf);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= '0;
         blad_q <= 1'b0;
      end else if (pc_ce) begin
         pc_q   <= pc_d;
         blad_q <= blad_d;
      end
   end

   stos_pc_lifo #(
      .DEPTH(STOS_GLEBOKOSC),
      .W    (PC_WIDTH)
   ) u_stos (
      .clk      (clk),
      .rst      (rst),
      .ce       (pc_ce),
      .clear    (lifo_clear),
      .push     (lifo_push),
      .pop      (lifo_pop),
      .din      (push_val),
      .top      (lifo_top),
      .empty    (lifo_empty),
      .full     (lifo_full),
      .overflow (lifo_ovf),
      .underflow(lifo_udf)
   );
endmodule
